// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register file write port between writeback and a multicycle unit, with a pending-register scoreboard
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        hold_wb,
  input  logic        mc_valid,
  input  logic [4:0]  mc_reg,
  input  logic [31:0] mc_data,
  output logic        mc_ready,
  input  logic        mc_issue,
  input  logic [4:0]  mc_issue_reg,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  output logic        hazard_rs1,
  output logic        hazard_rs2,
  output logic        hazard_rd,
  output logic        rf_write,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data,
  output logic [5:0]  pend_cnt
);
  logic [31:0] pending, pending_nx, set_mask, clr_mask;
  logic [3:0]  wait_cnt, wait_inc, wait_nx;
  logic        hold_nx, wb_noop, mc_xfer, starve, wb_pass;
  assign wb_noop    = !wb_en || wb_reg == 5'd0;
  assign mc_ready   = hold_wb || wb_noop;
  assign mc_xfer    = mc_valid && mc_ready;
  assign starve     = mc_valid && !mc_ready;
  assign wb_pass    = wb_en && !hold_wb;
  assign hazard_rs1 = pending[rs1];
  assign hazard_rs2 = pending[rs2];
  assign hazard_rd  = pending[rd];
  // write port mux: an accepted multicycle result wins, otherwise an unheld writeback
  always_comb begin
    rf_write      = mc_xfer ? mc_reg != 5'd0 : wb_pass && wb_reg != 5'd0;
    rf_write_reg  = mc_xfer ? mc_reg : wb_pass ? wb_reg : 5'd0;
    rf_write_data = mc_xfer ? mc_data : wb_pass ? wb_data : 32'd0;
  end
  // starvation counting and scoreboard next state; bit 0 is never pending, issue beats completion
  always_comb begin
    wait_inc   = wait_cnt + 4'd1;
    hold_nx    = starve && wait_inc == 4'(STARVE_LIMIT);
    wait_nx    = (starve && !hold_nx) ? wait_inc : 4'd0;
    set_mask   = mc_issue ? 32'd1 << mc_issue_reg : 32'd0;
    clr_mask   = mc_xfer ? 32'd1 << mc_reg : 32'd0;
    pending_nx = ((pending & ~clr_mask) | set_mask) & ~32'd1;
  end
  // state registers; pend_cnt tracks the popcount of the new pending set
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      pend_cnt <= '0;
      wait_cnt <= '0;
      hold_wb  <= 1'b0;
    end else begin
      pending  <= pending_nx;
      pend_cnt <= 6'($countones(pending_nx));
      wait_cnt <= wait_nx;
      hold_wb  <= hold_nx;
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios plus randomized traffic against a behavioural model
module tb_rf_wb_arbiter;
  localparam int LIMIT = 4;
  logic        clk = 1'b0;
  logic        rst, wb_en, mc_valid, mc_issue;
  logic [4:0]  wb_reg, mc_reg, mc_issue_reg, rs1, rs2, rd, rf_write_reg;
  logic [31:0] wb_data, mc_data, rf_write_data;
  logic        hold_wb, mc_ready, hazard_rs1, hazard_rs2, hazard_rd, rf_write;
  logic [5:0]  pend_cnt;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .hold_wb(hold_wb), .mc_valid(mc_valid), .mc_reg(mc_reg), .mc_data(mc_data),
    .mc_ready(mc_ready), .mc_issue(mc_issue), .mc_issue_reg(mc_issue_reg),
    .rs1(rs1), .rs2(rs2), .rd(rd), .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
    .hazard_rd(hazard_rd), .rf_write(rf_write), .rf_write_reg(rf_write_reg),
    .rf_write_data(rf_write_data), .pend_cnt(pend_cnt)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    rst = 0; wb_en = 0; wb_reg = 0; wb_data = 0; mc_valid = 0; mc_reg = 0; mc_data = 0;
    mc_issue = 0; mc_issue_reg = 0; rs1 = 0; rs2 = 0; rd = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset;
    do_reset();
    mc_issue = 1; mc_issue_reg = 5;
    tick();
    mc_issue = 0; rs1 = 5; #1;
    checks++;
    if (hazard_rs1 !== 1'b1) begin failures++; $display("FAIL reset_pre_hazard: got %b want 1", hazard_rs1); end
    rst = 1; mc_issue = 1; mc_issue_reg = 5;
    tick();
    rst = 0; mc_issue = 0; rs1 = 5; rd = 5; #1;
    checks++;
    if ({hold_wb, pend_cnt, hazard_rs1, hazard_rd} !== 9'b0)
      begin failures++; $display("FAIL reset_state: hold=%b cnt=%0d hz1=%b hzd=%b want all 0", hold_wb, pend_cnt, hazard_rs1, hazard_rd); end
    checks++;
    if (mc_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", mc_ready); end
  endtask

  task automatic test_idle_wb;
    do_reset();
    mc_valid = 1; mc_reg = 7; mc_data = 32'hDEADBEEF; #1;
    checks++;
    if ({mc_ready, rf_write, rf_write_reg, rf_write_data} !== {1'b1, 1'b1, 5'd7, 32'hDEADBEEF})
      begin failures++; $display("FAIL idle_wb: ready=%b wr=%b reg=%0d data=%h want 1 1 7 deadbeef", mc_ready, rf_write, rf_write_reg, rf_write_data); end
    tick();
    mc_valid = 0;
  endtask

  task automatic test_collision;
    do_reset();
    wb_en = 1; wb_reg = 3; wb_data = 32'hAAAA0003;
    mc_valid = 1; mc_reg = 4; mc_data = 32'hBBBB0004;
    for (int c = 1; c <= LIMIT; c++) begin
      #1;
      checks++;
      if ({hold_wb, mc_ready, rf_write, rf_write_reg, rf_write_data} !== {1'b0, 1'b0, 1'b1, 5'd3, 32'hAAAA0003})
        begin failures++; $display("FAIL collision_wb c%0d: hold=%b ready=%b wr=%b reg=%0d data=%h want 0 0 1 3 aaaa0003", c, hold_wb, mc_ready, rf_write, rf_write_reg, rf_write_data); end
      tick();
    end
    #1;
    checks++;
    if ({hold_wb, mc_ready, rf_write, rf_write_reg, rf_write_data} !== {1'b1, 1'b1, 1'b1, 5'd4, 32'hBBBB0004})
      begin failures++; $display("FAIL collision_hold: hold=%b ready=%b wr=%b reg=%0d data=%h want 1 1 1 4 bbbb0004", hold_wb, mc_ready, rf_write, rf_write_reg, rf_write_data); end
    tick();
    mc_valid = 0; #1;
    checks++;
    if ({hold_wb, rf_write, rf_write_reg, rf_write_data} !== {1'b0, 1'b1, 5'd3, 32'hAAAA0003})
      begin failures++; $display("FAIL collision_after: hold=%b wr=%b reg=%0d data=%h want 0 1 3 aaaa0003", hold_wb, rf_write, rf_write_reg, rf_write_data); end
    wb_en = 0;
  endtask

  task automatic test_scoreboard;
    do_reset();
    mc_issue = 1; mc_issue_reg = 9;
    tick();
    mc_issue = 0; rs2 = 9; #1;
    checks++;
    if ({hazard_rs2, pend_cnt} !== {1'b1, 6'd1}) begin failures++; $display("FAIL sb_issue: hz2=%b cnt=%0d want 1 1", hazard_rs2, pend_cnt); end
    mc_valid = 1; mc_reg = 9; mc_data = 32'h12345678; #1;
    checks++;
    if ({hazard_rs2, rf_write, rf_write_reg} !== {1'b1, 1'b1, 5'd9}) begin failures++; $display("FAIL sb_complete: hz2=%b wr=%b reg=%0d want 1 1 9", hazard_rs2, rf_write, rf_write_reg); end
    tick();
    mc_valid = 0; #1;
    checks++;
    if ({hazard_rs2, pend_cnt} !== {1'b0, 6'd0}) begin failures++; $display("FAIL sb_cleared: hz2=%b cnt=%0d want 0 0", hazard_rs2, pend_cnt); end
  endtask

  task automatic test_same_cycle;
    do_reset();
    mc_issue = 1; mc_issue_reg = 12;
    tick();
    mc_valid = 1; mc_reg = 12; mc_data = 32'hC0FFEE12;
    tick();
    mc_issue = 0; mc_valid = 0; rd = 12; #1;
    checks++;
    if ({hazard_rd, pend_cnt} !== {1'b1, 6'd1}) begin failures++; $display("FAIL same_cycle: hzd=%b cnt=%0d want 1 1", hazard_rd, pend_cnt); end
  endtask

  task automatic test_reg0;
    do_reset();
    wb_en = 1; wb_reg = 0; wb_data = 32'h55555555; mc_issue = 1; mc_issue_reg = 0; #1;
    checks++;
    if ({rf_write, mc_ready} !== 2'b01) begin failures++; $display("FAIL reg0_write: wr=%b ready=%b want 0 1", rf_write, mc_ready); end
    tick();
    mc_issue = 0; wb_en = 0; rs1 = 0; rd = 0; #1;
    checks++;
    if ({pend_cnt, hazard_rs1, hazard_rd} !== 8'd0) begin failures++; $display("FAIL reg0_pending: cnt=%0d hz1=%b hzd=%b want 0 0 0", pend_cnt, hazard_rs1, hazard_rd); end
  endtask

  task automatic test_random;
    int waited, cnt;
    bit hold, prev_hold, xfer, rdy, wr;
    bit pend [32];
    logic [4:0]  wreg;
    logic [31:0] wdat;
    logic [48:0] exp_v, got_v;
    waited = 0; hold = 0; prev_hold = 0; xfer = 0;
    foreach (pend[k]) pend[k] = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!prev_hold) begin wb_en = ($urandom_range(0, 3) != 0); wb_reg = 5'($urandom_range(0, 7)); wb_data = $urandom; end
      if (!mc_valid || xfer) begin mc_valid = ($urandom_range(0, 2) != 0); mc_reg = 5'($urandom_range(0, 7)); mc_data = $urandom; end
      mc_issue = ($urandom_range(0, 3) == 0); mc_issue_reg = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      #1;
      rdy = hold || !wb_en || wb_reg == 0;
      xfer = mc_valid && rdy;
      if (xfer) begin wr = (mc_reg != 0); wreg = mc_reg; wdat = mc_data; end
      else if (wb_en && !hold) begin wr = (wb_reg != 0); wreg = wb_reg; wdat = wb_data; end
      else begin wr = 0; wreg = 0; wdat = 0; end
      cnt = 0;
      foreach (pend[k]) cnt += int'(pend[k]);
      exp_v = {hold, rdy, wr, wreg, wdat, pend[rs1], pend[rs2], pend[rd], 6'(cnt)};
      got_v = {hold_wb, mc_ready, rf_write, rf_write_reg, rf_write_data, hazard_rs1, hazard_rs2, hazard_rd, pend_cnt};
      checks++;
      if (got_v !== exp_v) begin failures++; $display("FAIL random cycle %0d: got %h want %h", i, got_v, exp_v); end
      @(posedge clk);
      prev_hold = hold;
      if (rst) begin
        waited = 0; hold = 0;
        foreach (pend[k]) pend[k] = 0;
      end else begin
        if (mc_valid && !rdy) begin
          waited++;
          hold = (waited == LIMIT);
          if (hold) waited = 0;
        end else begin
          waited = 0; hold = 0;
        end
        if (xfer) pend[mc_reg] = 0;
        if (mc_issue && mc_issue_reg != 0) pend[mc_issue_reg] = 1;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_idle_wb();
    test_collision();
    test_scoreboard();
    test_same_cycle();
    test_reg0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
